// File: rtl/jk_counter_bank.sv
// jk_counter_bank: WIDTH-bit JK flip-flop bank with hold, per-bit JK and modulo up/down count modes.
// Define JK_COUNTER_BANK_COUNT_EN to build the counter; without it count modes hold and tc is 0.

module jk_bit (
  input  logic clk,
  input  logic r,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or negedge r) begin
    if (!r) q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_counter_bank #(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = longint'(1) << WIDTH
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  // Every mode is expressed as per-bit J/K drive; hold is J=K=0.
  logic [WIDTH-1:0] j_eff, k_eff;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_bit u_bit (.clk(clk), .r(r), .j(j_eff[i]), .k(k_eff[i]), .q(Q[i]));
  end

`ifdef JK_COUNTER_BANK_COUNT_EN
  logic [WIDTH-1:0] up_t, dn_t;
  logic             tc_nxt;

  // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin : toggles
    logic u, d;
    u = 1'b1;
    d = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = u;
      dn_t[i] = d;
      u = u & Q[i];
      d = d & ~Q[i];
    end
  end

  always_comb begin
    j_eff  = '0;
    k_eff  = '0;
    tc_nxt = 1'b0;
    if (en) begin
      case (mode)
        2'b01: begin
          j_eff = J;
          k_eff = K;
        end
        2'b10: begin
          if (Q >= MAXV) begin
            k_eff  = '1;
            tc_nxt = 1'b1;
          end else begin
            j_eff = up_t;
            k_eff = up_t;
          end
        end
        2'b11: begin
          // Zero wraps with tc; out-of-range values recover to MAXV silently.
          if (Q == '0 || Q > MAXV) begin
            j_eff  = MAXV;
            k_eff  = ~MAXV;
            tc_nxt = (Q == '0);
          end else begin
            j_eff = dn_t;
            k_eff = dn_t;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) tc <= 1'b0;
    else    tc <= tc_nxt;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^MAXV;

  always_comb begin
    j_eff = '0;
    k_eff = '0;
    if (en && mode == 2'b01) begin
      j_eff = J;
      k_eff = K;
    end
  end

  assign tc = 1'b0;
`endif

endmodule

// File: tb/tb_jk_counter_bank.sv
// Bench for jk_counter_bank (WIDTH=4, MODULUS=10): JK vector table, count/reset corner sequences, random vs model.
module tb_jk_counter_bank;
  localparam int     W = 4;
  localparam longint M = 10;
`ifdef JK_COUNTER_BANK_COUNT_EN
  localparam bit COUNT = 1'b1;
`else
  localparam bit COUNT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         r = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] J = '0;
  logic [W-1:0] K = '0;
  logic [W-1:0] Q;
  logic         tc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    logic         tc;
  } vec_t;

  vec_t vt[8];

  jk_counter_bank #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .r(r), .en(en), .mode(mode), .J(J), .K(K), .Q(Q), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic [1:0] md, input logic [W-1:0] j, input logic [W-1:0] k);
    en = e; mode = md; J = j; K = k;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    step(1'b1, 2'b01, v, ~v);
  endtask

  // Reference: next state straight from the mode rules with plain arithmetic.
  function automatic void model(input logic [W-1:0] q, input logic e, input logic [1:0] md,
                                input logic [W-1:0] j, input logic [W-1:0] k,
                                output logic [W-1:0] nq, output logic ntc);
    int v;
    v   = int'(q);
    nq  = q;
    ntc = 1'b0;
    if (!e) return;
    case (md)
      2'b01: nq = (j & ~q) | (~k & q);
      2'b10: if (COUNT) begin
        if (v >= M - 1) begin nq = '0; ntc = 1'b1; end
        else nq = W'(v + 1);
      end
      2'b11: if (COUNT) begin
        if (v == 0) begin nq = W'(M - 1); ntc = 1'b1; end
        else if (v > M - 1) nq = W'(M - 1);
        else nq = W'(v - 1);
      end
      default: ;
    endcase
  endfunction

  initial begin
    logic [W-1:0] mq;
    logic         mtc;
    int           pulses;

    vt[0] = '{1'b1, 2'b01, 4'b1010, 4'b0000, 4'b1010, 1'b0};
    vt[1] = '{1'b1, 2'b01, 4'b0011, 4'b0101, 4'b1011, 1'b0};
    vt[2] = '{1'b0, 2'b01, 4'b1111, 4'b1111, 4'b1011, 1'b0};
    vt[3] = '{1'b1, 2'b00, 4'b1111, 4'b1111, 4'b1011, 1'b0};
    vt[4] = '{1'b1, 2'b01, 4'b1111, 4'b1111, 4'b0100, 1'b0};
    vt[5] = '{1'b1, 2'b01, 4'b0000, 4'b1111, 4'b0000, 1'b0};
    vt[6] = '{1'b1, 2'b01, 4'b1111, 4'b0000, 4'b1111, 1'b0};
    vt[7] = '{1'b1, 2'b01, 4'b0110, 4'b1001, 4'b0110, 1'b0};

    #12;
    chk("reset_q", Q, 0);
    chk("reset_tc", tc, 0);
    r = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].en, vt[i].mode, vt[i].j, vt[i].k);
      chk($sformatf("vec%0d_q", i), Q, vt[i].q);
      chk($sformatf("vec%0d_tc", i), tc, vt[i].tc);
    end

`ifdef JK_COUNTER_BANK_COUNT_EN
    // Up wrap over 25 cycles from 0.
    load('0);
    pulses = 0;
    for (int c = 1; c <= 25; c++) begin
      step(1'b1, 2'b10, '0, '0);
      chk($sformatf("up%0d_q", c), Q, c % 10);
      chk($sformatf("up%0d_tc", c), tc, (c % 10) == 0);
      pulses += int'(tc);
    end
    chk("up_pulses", pulses, 2);

    // Down wrap, then out-of-range recovery.
    load(4'd1);
    step(1'b1, 2'b11, '0, '0);
    chk("dn1_q", Q, 0);
    chk("dn1_tc", tc, 0);
    step(1'b1, 2'b11, '0, '0);
    chk("dn_wrap_q", Q, 9);
    chk("dn_wrap_tc", tc, 1);
    load(4'hE);
    chk("load_e", Q, 4'hE);
    step(1'b1, 2'b11, '0, '0);
    chk("recov_q", Q, 9);
    chk("recov_tc", tc, 0);

    // Enable gating and per-cycle mode switching.
    load(4'd5);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 2'b10, '0, '0);
      chk("en0_q", Q, 5);
    end
    for (int c = 0; c < 4; c++) begin
      step(1'b1, (c % 2) ? 2'b11 : 2'b10, '0, '0);
      chk($sformatf("sw%0d_q", c), Q, (c % 2) ? 5 : 6);
      chk($sformatf("sw%0d_tc", c), tc, 0);
    end

    // Get tc high so the async reset has something to clear.
    load(4'd9);
    step(1'b1, 2'b10, '0, '0);
    chk("pre_rst_tc", tc, 1);
`else
    load(4'd3);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 2'b10, '0, '0);
      chk($sformatf("off_up%0d_q", c), Q, 3);
      chk($sformatf("off_up%0d_tc", c), tc, 0);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 2'b11, '0, '0);
      chk("off_dn_q", Q, 3);
      chk("off_dn_tc", tc, 0);
    end
    load(4'h5);
    chk("pre_rst_q", Q, 5);
`endif

    // Asynchronous reset mid-cycle, then held against counting.
    #2 r = 1'b0;
    #1;
    chk("async_rst_q", Q, 0);
    chk("async_rst_tc", tc, 0);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 2'b10, 4'hF, 4'h0);
      chk("rst_hold_q", Q, 0);
    end
    r = 1'b1;

    // Random traffic against the model, with occasional async resets.
    mq = '0;
    for (int c = 0; c < 400; c++) begin
      logic         e;
      logic [1:0]   md;
      logic [W-1:0] j, k;
      e  = ($urandom % 8) != 0;
      md = 2'($urandom);
      j  = W'($urandom);
      k  = W'($urandom);
      model(mq, e, md, j, k, mq, mtc);
      step(e, md, j, k);
      chk($sformatf("rnd%0d_q", c), Q, mq);
      chk($sformatf("rnd%0d_tc", c), tc, mtc);
      if (($urandom % 40) == 0) begin
        #2 r = 1'b0;
        #1;
        chk("rnd_rst_q", Q, 0);
        chk("rnd_rst_tc", tc, 0);
        r  = 1'b1;
        mq = '0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
